ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle main control decoder.
- Decodes the full RV32I opcode set into a control bundle in ID and carries it through registered ID/EX, EX/MEM and MEM/WB stages.
- Adds load-use hazard detection with bubble insertion, branch flush, a global freeze, and illegal-opcode flagging.
- Sits between the IF/ID register and the datapath; every stage's muxes and write enables are driven from its outputs.

Parameters:
- REG_AW, 5, register-address width (rs1/rs2/rd)
- ULA_OP_W, 2, width of the ULA operation-class field
- HAZARD_EN, 1, 1 enables load-use detection; 0 ties stall low

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  IF/ID holds a real instruction
- opcode  in  7  instr[6:0] in ID
- rs1  in  REG_AW  source register 1 in ID
- rs2  in  REG_AW  source register 2 in ID
- rd  in  REG_AW  destination register in ID
- flush_ex  in  1  branch/jump taken, resolved in EX
- freeze  in  1  external hold (memory wait); all stages hold
- stall  out  1  load-use stall; IF/ID and PC must hold
- ex_valid, ex_mux_ula, ex_ula_op[ULA_OP_W], ex_branch, ex_jump, ex_jal_reg, ex_pc_src_a  out  EX-stage controls
- ex_rd  out  REG_AW  destination register in EX
- ex_illegal  out  1  instruction in EX had an illegal opcode
- mem_valid, mem_rd, mem_wr  out  1 each  MEM-stage controls
- mem_rd_addr  out  REG_AW  destination register in MEM
- wb_valid, wb_reg_wr  out  1 each  WB-stage controls
- wb_sel  out  2  writeback source: 00 ULA, 01 memory, 10 PC+4
- wb_rd  out  REG_AW  destination register in WB

Behaviour:
- Decode (combinational, ID). Listed fields are 1; all others 0. ula_op: 00 add, 01 R/I funct-driven, 10 compare.
  - R 0110011: reg_wr, ula_op=01.
  - I 0010011: reg_wr, mux_ula, ula_op=01.
  - Load 0000011: reg_wr, mux_ula, mem_rd, wb_sel=01.
  - Store 0100011: mux_ula, mem_wr.
  - Branch 1100011: branch, ula_op=10.
  - LUI 0110111: reg_wr, mux_ula.
  - AUIPC 0010111: reg_wr, mux_ula, pc_src_a.
  - JAL 1101111: reg_wr, jump, wb_sel=10.
  - JALR 1100111: reg_wr, jump, jal_reg, mux_ula, wb_sel=10.
  - FENCE 0001111 and SYSTEM 1110011: NOP bundle.
  - Any other opcode: NOP bundle with illegal=1.
- rd == 0 forces reg_wr=0 at decode.
- Register-use sets:
  - rs1 used by R, I, load, store, branch, JALR.
  - rs2 used by R, store, branch.
- Load-use hazard: stall = HAZARD_EN & id_valid & ex_valid & ex mem_rd & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)). stall is combinational.
- Bubble: valid=0, all enables/branch/jump/illegal 0, rd=0.
- Stage update, evaluated at each rising edge in priority order:
  1. !rst_n: all stages become bubbles.
  2. freeze: all three registers hold; stall output still computed.
  3. flush_ex: ID/EX <- bubble. The EX instruction itself advances to MEM normally.
  4. stall: ID/EX <- bubble; EX/MEM and MEM/WB advance.
  5. Otherwise: ID/EX <- decoded bundle gated by id_valid (id_valid=0 loads a bubble); EX/MEM <- ID/EX; MEM/WB <- EX/MEM.
- Simultaneous flush_ex and stall: flush wins. The stalled instruction is wrong-path, so it is squashed, not retried.
- Latency: decoded bundle appears on ex_* 1 cycle after capture, mem_* after 2, wb_* after 3.
- Reset mid-operation: the next edge with rst_n=0 clears every stage; no partial writes leak, since wb_reg_wr and mem_wr are 0 from that edge.
- ex_illegal is only asserted while ex_valid=1.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM);
  - ula_op encodings and wb_sel encodings;
  - the ctrl_bundle_t struct and the NOP bundle constant.
- One sub-module, ctrl_decode: purely combinational opcode-to-bundle decode plus rs1/rs2-use flags. Reusable by a future single-cycle core.
- Hazard logic and the three stage registers stay in ctrl_pipe.

Test Plan:
- Reset, then opcode=0110011 rd=5 with id_valid=1 for 1 cycle -> ex_valid=1, ex_ula_op=01 at T+1; wb_reg_wr=1, wb_rd=5, wb_sel=00 at T+3.
- Load rd=7 captured, then next ID add rs1=7 -> stall=1 for exactly 1 cycle; bubble in EX (ex_valid=0); the add reaches EX one cycle later.
- Same as previous but rd=0 on the load, or a store using rs2=7 after a load to x7 -> stall=0 for rd=0; stall=1 for the store.
- Branch in EX with flush_ex=1 while ID holds a load-use hazard -> ID/EX becomes a bubble, branch advances to MEM, stall does not repeat the next cycle.
- freeze=1 for 3 cycles with a JAL in EX -> ex_* stable for 3 cycles; on release the JAL reaches WB with wb_sel=10.
- opcode=1111111 -> ex_illegal=1 with ex_valid=1, all write enables 0. rst_n=0 asserted while a store is in EX -> mem_wr=0 from the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions: RV32I opcodes, ULA class and writeback encodings,
// and the per-instruction control bundle carried down the pipeline.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_FUNCT = 2'b01;
    localparam logic [1:0] ULA_CMP   = 2'b10;

    localparam logic [1:0] WB_ULA    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    // ula_op and rd are carried beside the bundle because their widths are parameters.
    typedef struct packed {
        logic       valid;
        logic       reg_wr;
        logic       mux_ula;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic       jal_reg;
        logic       pc_src_a;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_bundle_t;

    // All-zero bundle: doubles as the pipeline bubble (valid=0).
    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I opcode decode into a control bundle plus source-register use flags.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ULA_OP_W = 2
) (
    input  logic [6:0]          opcode,
    input  logic [REG_AW-1:0]   rd,
    output ctrl_bundle_t        ctrl,
    output logic [ULA_OP_W-1:0] ula_op,
    output logic                rs1_used,
    output logic                rs2_used
);

    // Opcode to control bundle; writes to x0 are suppressed here so later stages never see them.
    always_comb begin
        ctrl       = CTRL_NOP;
        ctrl.valid = 1'b1;
        ula_op     = ULA_OP_W'(ULA_ADD);
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_wr = 1'b1;
                ula_op      = ULA_OP_W'(ULA_FUNCT);
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
            end
            OP_I: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.mux_ula = 1'b1;
                ula_op       = ULA_OP_W'(ULA_FUNCT);
                rs1_used     = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.mux_ula = 1'b1;
                ctrl.mem_rd  = 1'b1;
                ctrl.wb_sel  = WB_MEM;
                rs1_used     = 1'b1;
            end
            OP_STORE: begin
                ctrl.mux_ula = 1'b1;
                ctrl.mem_wr  = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ula_op      = ULA_OP_W'(ULA_CMP);
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.mux_ula = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.reg_wr   = 1'b1;
                ctrl.mux_ula  = 1'b1;
                ctrl.pc_src_a = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_wr = 1'b1;
                ctrl.jump   = 1'b1;
                ctrl.wb_sel = WB_PC4;
            end
            OP_JALR: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.jal_reg = 1'b1;
                ctrl.mux_ula = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                rs1_used     = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
            end
            default: ctrl.illegal = 1'b1;
        endcase
        if (rd == '0) begin
            ctrl.reg_wr = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined main control: ID decode, load-use stall, branch flush, freeze,
// and the ID/EX, EX/MEM, MEM/WB control registers.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ULA_OP_W  = 2,
    parameter int HAZARD_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [6:0]          opcode,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    input  logic [REG_AW-1:0]   rd,
    input  logic                flush_ex,
    input  logic                freeze,
    output logic                stall,
    output logic                ex_valid,
    output logic                ex_mux_ula,
    output logic [ULA_OP_W-1:0] ex_ula_op,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic                ex_jal_reg,
    output logic                ex_pc_src_a,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_illegal,
    output logic                mem_valid,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [REG_AW-1:0]   mem_rd_addr,
    output logic                wb_valid,
    output logic                wb_reg_wr,
    output logic [1:0]          wb_sel,
    output logic [REG_AW-1:0]   wb_rd
);

    ctrl_bundle_t        dec_ctrl;
    logic [ULA_OP_W-1:0] dec_ula_op;
    logic                dec_rs1_used;
    logic                dec_rs2_used;

    ctrl_bundle_t        idex_d, idex_q;
    logic [ULA_OP_W-1:0] idex_ula_op_d, idex_ula_op_q;
    logic [REG_AW-1:0]   idex_rd_d, idex_rd_q;

    logic                exmem_valid_d, exmem_valid_q;
    logic                exmem_reg_wr_d, exmem_reg_wr_q;
    logic                exmem_mem_rd_d, exmem_mem_rd_q;
    logic                exmem_mem_wr_d, exmem_mem_wr_q;
    logic [1:0]          exmem_wb_sel_d, exmem_wb_sel_q;
    logic [REG_AW-1:0]   exmem_rd_d, exmem_rd_q;

    logic                memwb_valid_d, memwb_valid_q;
    logic                memwb_reg_wr_d, memwb_reg_wr_q;
    logic [1:0]          memwb_wb_sel_d, memwb_wb_sel_q;
    logic [REG_AW-1:0]   memwb_rd_d, memwb_rd_q;

    ctrl_decode #(
        .REG_AW   (REG_AW),
        .ULA_OP_W (ULA_OP_W)
    ) u_decode (
        .opcode   (opcode),
        .rd       (rd),
        .ctrl     (dec_ctrl),
        .ula_op   (dec_ula_op),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Load in EX whose destination is read by the ID instruction; x0 never creates a dependency.
    always_comb begin
        stall = (HAZARD_EN != 0) && id_valid && idex_q.valid && idex_q.mem_rd
                && (idex_rd_q != '0)
                && ((dec_rs1_used && (rs1 == idex_rd_q)) ||
                    (dec_rs2_used && (rs2 == idex_rd_q)));
    end

    // Next-stage contents: freeze holds everything; flush (which also covers a
    // simultaneous stall, squashing the wrong-path instruction) or stall inserts a bubble.
    always_comb begin
        idex_d         = idex_q;
        idex_ula_op_d  = idex_ula_op_q;
        idex_rd_d      = idex_rd_q;
        exmem_valid_d  = exmem_valid_q;
        exmem_reg_wr_d = exmem_reg_wr_q;
        exmem_mem_rd_d = exmem_mem_rd_q;
        exmem_mem_wr_d = exmem_mem_wr_q;
        exmem_wb_sel_d = exmem_wb_sel_q;
        exmem_rd_d     = exmem_rd_q;
        memwb_valid_d  = memwb_valid_q;
        memwb_reg_wr_d = memwb_reg_wr_q;
        memwb_wb_sel_d = memwb_wb_sel_q;
        memwb_rd_d     = memwb_rd_q;
        if (!freeze) begin
            memwb_valid_d  = exmem_valid_q;
            memwb_reg_wr_d = exmem_reg_wr_q;
            memwb_wb_sel_d = exmem_wb_sel_q;
            memwb_rd_d     = exmem_rd_q;
            exmem_valid_d  = idex_q.valid;
            exmem_reg_wr_d = idex_q.reg_wr;
            exmem_mem_rd_d = idex_q.mem_rd;
            exmem_mem_wr_d = idex_q.mem_wr;
            exmem_wb_sel_d = idex_q.wb_sel;
            exmem_rd_d     = idex_rd_q;
            if (flush_ex || stall || !id_valid) begin
                idex_d        = CTRL_NOP;
                idex_ula_op_d = '0;
                idex_rd_d     = '0;
            end else begin
                idex_d        = dec_ctrl;
                idex_ula_op_d = dec_ula_op;
                idex_rd_d     = rd;
            end
        end
    end

    // Stage registers with synchronous active-low clear to bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q         <= CTRL_NOP;
            idex_ula_op_q  <= '0;
            idex_rd_q      <= '0;
            exmem_valid_q  <= 1'b0;
            exmem_reg_wr_q <= 1'b0;
            exmem_mem_rd_q <= 1'b0;
            exmem_mem_wr_q <= 1'b0;
            exmem_wb_sel_q <= WB_ULA;
            exmem_rd_q     <= '0;
            memwb_valid_q  <= 1'b0;
            memwb_reg_wr_q <= 1'b0;
            memwb_wb_sel_q <= WB_ULA;
            memwb_rd_q     <= '0;
        end else begin
            idex_q         <= idex_d;
            idex_ula_op_q  <= idex_ula_op_d;
            idex_rd_q      <= idex_rd_d;
            exmem_valid_q  <= exmem_valid_d;
            exmem_reg_wr_q <= exmem_reg_wr_d;
            exmem_mem_rd_q <= exmem_mem_rd_d;
            exmem_mem_wr_q <= exmem_mem_wr_d;
            exmem_wb_sel_q <= exmem_wb_sel_d;
            exmem_rd_q     <= exmem_rd_d;
            memwb_valid_q  <= memwb_valid_d;
            memwb_reg_wr_q <= memwb_reg_wr_d;
            memwb_wb_sel_q <= memwb_wb_sel_d;
            memwb_rd_q     <= memwb_rd_d;
        end
    end

    // Stage outputs straight from the registers.
    always_comb begin
        ex_valid    = idex_q.valid;
        ex_mux_ula  = idex_q.mux_ula;
        ex_ula_op   = idex_ula_op_q;
        ex_branch   = idex_q.branch;
        ex_jump     = idex_q.jump;
        ex_jal_reg  = idex_q.jal_reg;
        ex_pc_src_a = idex_q.pc_src_a;
        ex_rd       = idex_rd_q;
        ex_illegal  = idex_q.illegal & idex_q.valid;
        mem_valid   = exmem_valid_q;
        mem_rd      = exmem_mem_rd_q;
        mem_wr      = exmem_mem_wr_q;
        mem_rd_addr = exmem_rd_q;
        wb_valid    = memwb_valid_q;
        wb_reg_wr   = memwb_reg_wr_q;
        wb_sel      = memwb_wb_sel_q;
        wb_rd       = memwb_rd_q;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed-vector bench for ctrl_pipe with immediate-assertion checks.
module tb_ctrl_pipe;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       flush_ex, freeze;
    logic       stall;
    logic       ex_valid, ex_mux_ula, ex_branch, ex_jump, ex_jal_reg, ex_pc_src_a, ex_illegal;
    logic [1:0] ex_ula_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_rd, mem_wr;
    logic [4:0] mem_rd_addr;
    logic       wb_valid, wb_reg_wr;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;

    int checks = 0;
    int errors = 0;

    ctrl_pipe #(.REG_AW(5), .ULA_OP_W(2), .HAZARD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .flush_ex(flush_ex), .freeze(freeze),
        .stall(stall), .ex_valid(ex_valid), .ex_mux_ula(ex_mux_ula),
        .ex_ula_op(ex_ula_op), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jal_reg(ex_jal_reg), .ex_pc_src_a(ex_pc_src_a), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rd_addr(mem_rd_addr), .wb_valid(wb_valid),
        .wb_reg_wr(wb_reg_wr), .wb_sel(wb_sel), .wb_rd(wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] d);
        id_valid = v;
        opcode   = op;
        rs1      = s1;
        rs2      = s2;
        rd       = d;
    endtask

    initial begin
        rst_n = 1'b0; flush_ex = 1'b0; freeze = 1'b0;
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", stall, 0);

        // R-type through all stages
        set_id(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd5);
        tick();
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        chk("r_ex_valid", ex_valid, 1);
        chk("r_ex_ula_op", ex_ula_op, 2'b01);
        chk("r_ex_mux_ula", ex_mux_ula, 0);
        chk("r_ex_rd", ex_rd, 5);
        tick();
        chk("r_mem_valid", mem_valid, 1);
        chk("r_mem_rd_addr", mem_rd_addr, 5);
        tick();
        chk("r_wb_valid", wb_valid, 1);
        chk("r_wb_reg_wr", wb_reg_wr, 1);
        chk("r_wb_rd", wb_rd, 5);
        chk("r_wb_sel", wb_sel, 2'b00);

        // load x7, then add reading x7: one-cycle stall
        set_id(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7);
        tick();
        chk("ld_ex_mux_ula", ex_mux_ula, 1);
        set_id(1'b1, 7'b0110011, 5'd7, 5'd3, 5'd8);
        #1;
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_mem_rd", mem_rd, 1);
        chk("lu_stall_gone", stall, 0);
        tick();
        chk("lu_add_ex_valid", ex_valid, 1);
        chk("lu_add_ex_rd", ex_rd, 8);
        chk("lu_ld_wb_sel", wb_sel, 2'b01);
        chk("lu_ld_wb_reg_wr", wb_reg_wr, 1);
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick(); tick();

        // load to x0 never stalls, and its write is suppressed
        set_id(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 7'b0110011, 5'd0, 5'd0, 5'd9);
        #1;
        chk("x0_stall", stall, 0);
        tick();
        chk("x0_add_ex_rd", ex_rd, 9);
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("x0_ld_wb_reg_wr", wb_reg_wr, 0);
        tick(); tick();

        // load x7, then I-type with rs2 field 7 (unused): no stall; then store using rs2=7: stall
        set_id(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7);
        tick();
        set_id(1'b1, 7'b0010011, 5'd2, 5'd7, 5'd3);
        #1;
        chk("i_rs2_stall", stall, 0);
        set_id(1'b1, 7'b0100011, 5'd1, 5'd7, 5'd4);
        #1;
        chk("st_rs2_stall", stall, 1);
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick(); tick();

        // flush with a simultaneous load-use stall: flush wins, stall not repeated
        set_id(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7);
        tick();
        set_id(1'b1, 7'b0110011, 5'd7, 5'd3, 5'd8);
        flush_ex = 1'b1;
        #1;
        chk("fl_stall_pre", stall, 1);
        tick();
        flush_ex = 1'b0;
        chk("fl_ex_bubble", ex_valid, 0);
        chk("fl_mem_valid", mem_valid, 1);
        chk("fl_mem_rd_addr", mem_rd_addr, 7);
        chk("fl_stall_post", stall, 0);
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick(); tick();

        // branch in EX flushed: it still advances to MEM
        set_id(1'b1, 7'b1100011, 5'd1, 5'd2, 5'd0);
        tick();
        chk("br_ex_branch", ex_branch, 1);
        chk("br_ex_ula_op", ex_ula_op, 2'b10);
        set_id(1'b1, 7'b0110011, 5'd4, 5'd5, 5'd6);
        flush_ex = 1'b1;
        tick();
        flush_ex = 1'b0;
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        chk("br_flush_ex_valid", ex_valid, 0);
        chk("br_mem_valid", mem_valid, 1);
        chk("br_mem_wr", mem_wr, 0);
        tick(); tick(); tick();

        // freeze 3 cycles with JAL in EX
        set_id(1'b1, 7'b1101111, 5'd0, 5'd0, 5'd1);
        tick();
        chk("jal_ex_jump", ex_jump, 1);
        freeze = 1'b1;
        set_id(1'b1, 7'b0110011, 5'd2, 5'd3, 5'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_ex_jump", ex_jump, 1);
            chk("frz_ex_rd", ex_rd, 1);
            chk("frz_mem_valid", mem_valid, 0);
        end
        freeze = 1'b0;
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("jal_mem_valid", mem_valid, 1);
        tick();
        chk("jal_wb_sel", wb_sel, 2'b10);
        chk("jal_wb_reg_wr", wb_reg_wr, 1);
        chk("jal_wb_rd", wb_rd, 1);

        // JALR and AUIPC decode
        set_id(1'b1, 7'b1100111, 5'd3, 5'd0, 5'd2);
        tick();
        chk("jalr_jal_reg", ex_jal_reg, 1);
        chk("jalr_mux_ula", ex_mux_ula, 1);
        chk("jalr_jump", ex_jump, 1);
        set_id(1'b1, 7'b0010111, 5'd0, 5'd0, 5'd2);
        tick();
        chk("auipc_pc_src_a", ex_pc_src_a, 1);
        chk("auipc_jump", ex_jump, 0);

        // illegal opcode
        set_id(1'b1, 7'b1111111, 5'd0, 5'd0, 5'd3);
        tick();
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        chk("ill_ex_illegal", ex_illegal, 1);
        chk("ill_ex_valid", ex_valid, 1);
        chk("ill_ex_jump", ex_jump, 0);
        tick();
        chk("ill_mem_wr", mem_wr, 0);
        chk("ill_mem_rd", mem_rd, 0);
        chk("ill_ex_illegal_gone", ex_illegal, 0);
        tick();
        chk("ill_wb_valid", wb_valid, 1);
        chk("ill_wb_reg_wr", wb_reg_wr, 0);

        // store reaches MEM normally
        set_id(1'b1, 7'b0100011, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("st_mem_wr", mem_wr, 1);

        // reset while a store is in EX
        set_id(1'b1, 7'b0100011, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        chk("rst_st_in_ex", ex_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_mem_wr", mem_wr, 0);
        chk("rst_mid_ex_valid", ex_valid, 0);
        chk("rst_mid_wb_reg_wr", wb_reg_wr, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_mem_wr_after", mem_wr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
